// File: rtl/dp_ram_ind_r_w.sv
// Dual-port RAM: one write port, one independent read port, single clock.
// SYNC_READ selects combinational or registered read; define DP_RAM_RESET_CLEAR_EN to clear the array on reset.
module dp_ram_ind_r_w #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_DEPTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SYNC_READ  = 0
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  WrEn_SI,
  input  logic [ADDR_WIDTH-1:0] WrAddr_DI,
  input  logic [DATA_WIDTH-1:0] WrData_DI,
  input  logic [ADDR_WIDTH-1:0] RdAddr_DI,
  output logic [DATA_WIDTH-1:0] RdData_DO
);

  localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [0:DATA_DEPTH-1];

  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_wr_en;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Out-of-range addresses are compared one bit wider so DATA_DEPTH == 2**ADDR_WIDTH still fits.
  assign w_wr_in_range = ({1'b0, WrAddr_DI} < DEPTH_C);
  assign w_rd_in_range = ({1'b0, RdAddr_DI} < DEPTH_C);
  assign w_wr_idx      = WrAddr_DI[IDX_W-1:0];
  assign w_rd_idx      = RdAddr_DI[IDX_W-1:0];
  assign w_wr_en       = WrEn_SI & ~Rst_RI & w_wr_in_range;

`ifdef DP_RAM_RESET_CLEAR_EN
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      for (int i = 0; i < DATA_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= WrData_DI;
    end
  end
`else
  // No reset on the array so it maps onto block RAM; reset only gates the write.
  always_ff @(posedge Clk_CI) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= WrData_DI;
    end
  end
`endif

  assign w_rd_word = w_rd_in_range ? r_mem[w_rd_idx] : '0;

  generate
    if (SYNC_READ != 0) begin : g_sync_rd
      logic [DATA_WIDTH-1:0] r_rd_data_p1;

      // Samples the pre-write word, giving read-before-write on address collisions.
      always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
          r_rd_data_p1 <= '0;
        end else begin
          r_rd_data_p1 <= w_rd_word;
        end
      end

      assign RdData_DO = Rst_RI ? '0 : r_rd_data_p1;
    end else begin : g_async_rd
      assign RdData_DO = Rst_RI ? '0 : w_rd_word;
    end
  endgenerate

endmodule

// File: tb/tb_dp_ram_ind_r_w.sv
// Bench for dp_ram_ind_r_w: async depth 8, sync depth 8 and async depth 6 instances share one stimulus stream.
module tb_dp_ram_ind_r_w;

  typedef struct packed {
    logic [31:0] d;
    logic        k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_s = 1'b0;
  logic [2:0]  wa_s = '0;
  logic [31:0] wd_s = '0;
  logic [2:0]  ra_s = '0;
  logic [31:0] rd_a, rd_s, rd_d;

  logic [31:0] m8 [0:7];
  logic        k8 [0:7];
  logic [31:0] m6 [0:5];
  logic        k6 [0:5];
  exp_t        q_s [$];
  exp_t        last_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dp_ram_ind_r_w #(.ADDR_WIDTH(3), .DATA_DEPTH(8), .DATA_WIDTH(32), .SYNC_READ(0)) u_async (
    .Clk_CI(clk), .Rst_RI(rst), .WrEn_SI(we_s), .WrAddr_DI(wa_s), .WrData_DI(wd_s),
    .RdAddr_DI(ra_s), .RdData_DO(rd_a));

  dp_ram_ind_r_w #(.ADDR_WIDTH(3), .DATA_DEPTH(8), .DATA_WIDTH(32), .SYNC_READ(1)) u_sync (
    .Clk_CI(clk), .Rst_RI(rst), .WrEn_SI(we_s), .WrAddr_DI(wa_s), .WrData_DI(wd_s),
    .RdAddr_DI(ra_s), .RdData_DO(rd_s));

  dp_ram_ind_r_w #(.ADDR_WIDTH(3), .DATA_DEPTH(6), .DATA_WIDTH(32), .SYNC_READ(0)) u_d6 (
    .Clk_CI(clk), .Rst_RI(rst), .WrEn_SI(we_s), .WrAddr_DI(wa_s), .WrData_DI(wd_s),
    .RdAddr_DI(ra_s), .RdData_DO(rd_d));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check pre-edge view, clock, update model, check post-edge view.
  task automatic cyc(input logic we, input logic [2:0] wa, input logic [31:0] wd, input logic [2:0] ra);
    exp_t e;
    we_s = we; wa_s = wa; wd_s = wd; ra_s = ra;
    #1;
    if (k8[ra]) chk("async_pre", rd_a, m8[ra]);
    if (last_s.k) chk("sync_hold", rd_s, last_s.d);
    e.d = m8[ra];
    e.k = k8[ra];
    q_s.push_back(e);
    @(posedge clk);
    #1;
    if (we) begin
      m8[wa] = wd;
      k8[wa] = 1'b1;
      if (wa < 3'd6) begin
        m6[wa] = wd;
        k6[wa] = 1'b1;
      end
    end
    if (k8[ra]) chk("async_post", rd_a, m8[ra]);
    if (q_s.size() == 0) begin
      chk("sync_queue_empty", 32'd1, 32'd0);
    end else begin
      e = q_s.pop_front();
      if (e.k) chk("sync_rd", rd_s, e.d);
      last_s = e;
    end
    if (ra < 3'd6) begin
      if (k6[ra]) chk("d6_rd", rd_d, m6[ra]);
    end else begin
      chk("d6_oob_rd", rd_d, 32'd0);
    end
  endtask

  // Reset asserted mid-stream with a write pending; outputs must drop at once and the write is lost.
  task automatic rst_seq();
    we_s = 1'b1; wa_s = 3'd3; wd_s = 32'hBAD0BAD0; ra_s = 3'd3;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_imm", rd_a, 32'd0);
    chk("rst_sync_imm", rd_s, 32'd0);
    chk("rst_d6_imm", rd_d, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_sync_edge", rd_s, 32'd0);
    chk("rst_async_edge", rd_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    we_s = 1'b0;
`ifdef DP_RAM_RESET_CLEAR_EN
    for (int i = 0; i < 8; i++) begin m8[i] = '0; k8[i] = 1'b1; end
    for (int i = 0; i < 6; i++) begin m6[i] = '0; k6[i] = 1'b1; end
`endif
    last_s.d = '0;
    last_s.k = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m8[i] = '0; k8[i] = 1'b0; end
    for (int i = 0; i < 6; i++) begin m6[i] = '0; k6[i] = 1'b0; end
    last_s.d = '0;
    last_s.k = 1'b1;

    #2;
    chk("reset_async", rd_a, 32'd0);
    chk("reset_sync", rd_s, 32'd0);
    chk("reset_d6", rd_d, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back writes 0..7 with wrapping reads 7,0,1,...: sync data trails the address by one cycle.
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 32'(i), 3'(i + 7));

    cyc(1'b1, 3'd3, 32'hDEADBEEF, 3'd3);
    cyc(1'b0, 3'd0, 32'd0, 3'd4);
    cyc(1'b0, 3'd0, 32'd0, 3'd3);

    cyc(1'b1, 3'd5, 32'h12345678, 3'd0);
    cyc(1'b0, 3'd0, 32'd0, 3'd5);
    cyc(1'b0, 3'd0, 32'd0, 3'd5);

    cyc(1'b1, 3'd2, 32'hA, 3'd0);
    cyc(1'b1, 3'd2, 32'hB, 3'd2);
    cyc(1'b0, 3'd0, 32'd0, 3'd2);

    cyc(1'b1, 3'd7, 32'hFF, 3'd7);
    for (int i = 0; i < 8; i++) cyc(1'b0, 3'd0, 32'd0, 3'(i));

    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 32'(i), 3'(i));
    rst_seq();
    for (int i = 0; i < 8; i++) cyc(1'b0, 3'd0, 32'd0, 3'(i));
    cyc(1'b0, 3'd0, 32'd0, 3'd0);

    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom), 3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
